// File: rtl/armleocpu_ifetch_responder.sv
// armleocpu_ifetch_responder
//
// Responder end of the fetch-to-cache command interface. It replaces a full
// instruction cache in small configurations. A single line of LINE_WORDS
// words is buffered. EXECUTE hits are served from that line. On a miss the
// line is refilled over a burst memory port and the requested word is
// returned. FLUSH_ALL invalidates the line.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   c_cmd, c_address      command and byte address. The initiator holds both
//                         stable until c_done.
//   c_done                one-cycle completion pulse
//   c_response            CACHE_RESPONSE_* code, meaningful with c_done
//   c_load_data           fetched word. It holds its value between responses.
//   m_req_valid/ready     burst request handshake
//   m_req_addr            line-aligned burst start address
//   m_resp_valid/data/error  LINE_WORDS in-order beats per accepted request
//   stat_hits/stat_misses (only with ARMLEOCPU_IFETCH_RESP_STATS_EN defined)
//                         wrapping 32-bit hit and miss counters
//
// Handshake semantics: a burst request transfers on a rising edge where
// m_req_valid and m_req_ready are both high. m_req_valid and m_req_addr stay
// constant from assertion until that edge. Every cycle with m_resp_valid
// high in FILL is exactly one beat. Beats outside FILL are ignored. On the
// command side, a command completes in the cycle c_done is high. A command
// presented in that same cycle is a new request.
//
// Optional feature macro: ARMLEOCPU_IFETCH_RESP_STATS_EN

module armleocpu_ifetch_responder #(
  parameter int LINE_WORDS = 4,
  parameter int LINE_IDX_W = $clog2(LINE_WORDS)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  c_cmd,
  input  logic [31:0] c_address,
  output logic        c_done,
  output logic [3:0]  c_response,
  output logic [31:0] c_load_data,
`ifdef ARMLEOCPU_IFETCH_RESP_STATS_EN
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses,
`endif
  output logic        m_req_valid,
  input  logic        m_req_ready,
  output logic [31:0] m_req_addr,
  input  logic        m_resp_valid,
  input  logic [31:0] m_resp_data,
  input  logic        m_resp_error
);

  localparam logic [3:0] CACHE_CMD_NONE      = 4'd0;
  localparam logic [3:0] CACHE_CMD_EXECUTE   = 4'd1;
  localparam logic [3:0] CACHE_CMD_FLUSH_ALL = 4'd4;

  localparam logic [3:0] CACHE_RESPONSE_SUCCESS     = 4'd0;
  localparam logic [3:0] CACHE_RESPONSE_ACCESSFAULT = 4'd1;
  localparam logic [3:0] CACHE_RESPONSE_MISSALIGNED = 4'd3;
  localparam logic [3:0] CACHE_RESPONSE_UNKNOWNCMD  = 4'd4;

  localparam int TAG_W = 32 - 2 - LINE_IDX_W;
  localparam logic [LINE_IDX_W-1:0] LAST_BEAT = LINE_IDX_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_FILL    = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic                  line_valid_q;
  logic [TAG_W-1:0]      tag_q;
  logic [31:0]           line_q [LINE_WORDS];
  logic [LINE_IDX_W-1:0] beat_q;
  logic [LINE_IDX_W-1:0] req_idx_q;
  logic                  fill_err_q;
  logic [3:0]            resp_q;
  logic [31:0]           data_q;
  logic [31:0]           req_addr_q;

  logic [TAG_W-1:0]      addr_tag;
  logic [LINE_IDX_W-1:0] addr_idx;
  logic [TAG_W-1:0]      req_tag;

  assign addr_tag = c_address[31:2+LINE_IDX_W];
  assign addr_idx = c_address[2 +: LINE_IDX_W];
  assign req_tag  = req_addr_q[31:2+LINE_IDX_W];

  // Per-cycle decisions made by the FSM and applied by the datapath register.
  logic        resp_we, data_we;
  logic [3:0]  resp_d;
  logic [31:0] data_d;
  logic        do_hit, do_miss, do_flush, req_fire, beat_we, fill_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    resp_we  = 1'b0;
    resp_d   = CACHE_RESPONSE_SUCCESS;
    data_we  = 1'b0;
    data_d   = data_q;
    do_hit   = 1'b0;
    do_miss  = 1'b0;
    do_flush = 1'b0;
    req_fire = 1'b0;
    beat_we  = 1'b0;
    fill_ok  = 1'b0;
    case (state_q)
      // RESPOND evaluates the incoming command exactly like IDLE. This gives
      // back-to-back hits one response per cycle.
      ST_IDLE, ST_RESPOND: begin
        state_d = ST_IDLE;
        case (c_cmd)
          CACHE_CMD_NONE: state_d = ST_IDLE;
          CACHE_CMD_EXECUTE: begin
            if (c_address[1:0] != 2'b00) begin
              state_d = ST_RESPOND;
              resp_we = 1'b1;
              resp_d  = CACHE_RESPONSE_MISSALIGNED;
            end else if (line_valid_q && (tag_q == addr_tag)) begin
              do_hit  = 1'b1;
              state_d = ST_RESPOND;
              resp_we = 1'b1;
              data_we = 1'b1;
              data_d  = line_q[addr_idx];
            end else begin
              do_miss = 1'b1;
              state_d = ST_REQ;
            end
          end
          CACHE_CMD_FLUSH_ALL: begin
            do_flush = 1'b1;
            state_d  = ST_RESPOND;
            resp_we  = 1'b1;
          end
          default: begin
            state_d = ST_RESPOND;
            resp_we = 1'b1;
            resp_d  = CACHE_RESPONSE_UNKNOWNCMD;
          end
        endcase
      end
      ST_REQ: begin
        if (m_req_ready) begin
          req_fire = 1'b1;
          state_d  = ST_FILL;
        end
      end
      ST_FILL: begin
        if (m_resp_valid) begin
          beat_we = 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = ST_RESPOND;
            resp_we = 1'b1;
            if (!(fill_err_q || m_resp_error)) begin
              fill_ok = 1'b1;
              data_we = 1'b1;
              // The last beat is not in line_q yet, so it is forwarded
              // straight from the bus.
              data_d  = (req_idx_q == LAST_BEAT) ? m_resp_data : line_q[req_idx_q];
            end else begin
              resp_d = CACHE_RESPONSE_ACCESSFAULT;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_valid_q <= 1'b0;
      tag_q        <= '0;
      beat_q       <= '0;
      req_idx_q    <= '0;
      fill_err_q   <= 1'b0;
      resp_q       <= CACHE_RESPONSE_SUCCESS;
      data_q       <= '0;
      req_addr_q   <= '0;
    end else begin
      if (do_flush) line_valid_q <= 1'b0;
      // Capture the request on the miss decision. The burst and the final
      // word selection are then immune to c_cmd/c_address changing mid-fill.
      if (do_miss) begin
        req_addr_q <= {c_address[31:2+LINE_IDX_W], {(2+LINE_IDX_W){1'b0}}};
        req_idx_q  <= addr_idx;
      end
      if (req_fire) begin
        line_valid_q <= 1'b0;
        beat_q       <= '0;
        fill_err_q   <= 1'b0;
      end
      if (beat_we) begin
        beat_q     <= beat_q + 1'b1;
        fill_err_q <= fill_err_q | m_resp_error;
      end
      if (fill_ok) begin
        line_valid_q <= 1'b1;
        tag_q        <= req_tag;
      end
      if (resp_we) resp_q <= resp_d;
      if (data_we) data_q <= data_d;
    end
  end

  // Line storage has no reset. line_valid_q guards every read.
  always_ff @(posedge clk) begin
    if (beat_we) line_q[beat_q] <= m_resp_data;
  end

`ifdef ARMLEOCPU_IFETCH_RESP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else begin
      if (do_hit)  stat_hits   <= stat_hits + 32'd1;
      if (do_miss) stat_misses <= stat_misses + 32'd1;
    end
  end
`endif

  assign c_done      = (state_q == ST_RESPOND);
  assign c_response  = resp_q;
  assign c_load_data = data_q;
  assign m_req_valid = (state_q == ST_REQ);
  assign m_req_addr  = req_addr_q;

endmodule

// File: tb/tb_armleocpu_ifetch_responder.sv
`timescale 1ns/1ps
module tb_armleocpu_ifetch_responder;

  localparam int LW = 4;
  localparam logic [3:0] CMD_NONE      = 4'd0;
  localparam logic [3:0] CMD_EXECUTE   = 4'd1;
  localparam logic [3:0] CMD_FLUSH_ALL = 4'd4;
  localparam logic [3:0] RSP_SUCCESS     = 4'd0;
  localparam logic [3:0] RSP_ACCESSFAULT = 4'd1;
  localparam logic [3:0] RSP_MISSALIGNED = 4'd3;
  localparam logic [3:0] RSP_UNKNOWNCMD  = 4'd4;

  logic        clk, rst_n;
  logic [3:0]  c_cmd;
  logic [31:0] c_address;
  logic        c_done;
  logic [3:0]  c_response;
  logic [31:0] c_load_data;
  logic        m_req_valid, m_req_ready;
  logic [31:0] m_req_addr;
  logic        m_resp_valid;
  logic [31:0] m_resp_data;
  logic        m_resp_error;
`ifdef ARMLEOCPU_IFETCH_RESP_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  armleocpu_ifetch_responder #(.LINE_WORDS(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_cmd(c_cmd), .c_address(c_address),
    .c_done(c_done), .c_response(c_response), .c_load_data(c_load_data),
`ifdef ARMLEOCPU_IFETCH_RESP_STATS_EN
    .stat_hits(stat_hits), .stat_misses(stat_misses),
`endif
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_resp_valid(m_resp_valid), .m_resp_data(m_resp_data), .m_resp_error(m_resp_error)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // ---------------- reference model ----------------
  // The model is one buffered line described by its line address, plus the
  // memory contents as a pure function of the address.
  logic [36:0] exp_q[$];      // {data_valid, response[3:0], data[31:0]}
  logic [31:0] req_exp_q[$];  // expected burst start addresses, in order
  logic        model_valid = 1'b0;
  logic [31:0] model_line  = '0;
  int          model_hits = 0, model_misses = 0;
  int          err_beat = -1;
  int          first_delay = 3;
  logic        stray_en = 1'b0;
  int          mem_beat = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h0000100) return 32'hA0 + 32'(a[3:2]);
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [3:0] cmd, input logic [31:0] addr, input int eb, output int lat);
    logic [3:0]  r;
    logic        dv;
    logic [31:0] d;
    logic [31:0] la;
    r  = RSP_SUCCESS;
    dv = 1'b0;
    d  = '0;
    la = addr & ~32'hF;
    err_beat = eb;
    if (cmd == CMD_EXECUTE) begin
      if (addr[1:0] != 2'b00) r = RSP_MISSALIGNED;
      else if (model_valid && model_line == la) begin
        dv = 1'b1; d = mem_word(addr); model_hits++;
      end else begin
        model_misses++;
        req_exp_q.push_back(la);
        model_valid = 1'b0;
        if (eb >= 0 && eb < LW) r = RSP_ACCESSFAULT;
        else begin
          model_valid = 1'b1; model_line = la; dv = 1'b1; d = mem_word(addr);
        end
      end
    end else if (cmd == CMD_FLUSH_ALL) begin
      model_valid = 1'b0;
    end else if (cmd != CMD_NONE) begin
      r = RSP_UNKNOWNCMD;
    end
    exp_q.push_back({dv, r, d});
    c_cmd = cmd;
    c_address = addr;
    lat = 0;
    while (1) begin
      @(posedge clk); #1;
      lat++;
      if (c_done || lat >= 200) break;
    end
    if (!c_done) fail_now("done_timeout");
  endtask

  task automatic idle(input int n);
    c_cmd = CMD_NONE;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- memory model ----------------
  initial begin
    int phase, cnt, gap, d;
    logic [31:0] req_addr;
    phase = 0; cnt = 0; gap = 0; req_addr = '0;
    m_req_ready = 1'b0; m_resp_valid = 1'b0; m_resp_data = '0; m_resp_error = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        phase = 0; mem_beat = 0;
        m_req_ready = 1'b0; m_resp_valid = 1'b0; m_resp_error = 1'b0;
        continue;
      end
      case (phase)
        0: begin
          m_resp_valid = 1'b0; m_resp_error = 1'b0;
          if (m_req_valid) begin
            req_addr = m_req_addr;
            if (req_exp_q.size() == 0) fail_now("unexpected_m_req");
            else check("m_req_addr", m_req_addr, req_exp_q.pop_front());
            if (first_delay >= 0) begin d = first_delay; first_delay = -1; end
            else d = $urandom_range(0, 3);
            if (d == 0) begin m_req_ready = 1'b1; phase = 2; end
            else begin cnt = d; phase = 1; end
          end else if (stray_en && $urandom_range(0, 9) == 0) begin
            m_resp_valid = 1'b1; m_resp_data = $urandom; m_resp_error = 1'($urandom_range(0, 1));
          end
        end
        1: begin
          check("m_req_valid_held", {31'd0, m_req_valid}, 32'd1);
          check("m_req_addr_held", m_req_addr, req_addr);
          cnt--;
          if (cnt == 0) begin m_req_ready = 1'b1; phase = 2; end
        end
        2: begin
          check("m_req_valid_dropped", {31'd0, m_req_valid}, 32'd0);
          m_req_ready = 1'b0;
          mem_beat = 0;
          gap = $urandom_range(0, 2);
          phase = 3;
        end
        3: begin
          if (gap > 0) begin
            m_resp_valid = 1'b0; m_resp_error = 1'b0; gap--;
          end else begin
            m_resp_valid = 1'b1;
            m_resp_data  = mem_word(req_addr + 32'(4 * mem_beat));
            m_resp_error = (mem_beat == err_beat);
            mem_beat++;
            gap = $urandom_range(0, 2);
            if (mem_beat == LW) phase = 4;
          end
        end
        default: begin
          m_resp_valid = 1'b0; m_resp_error = 1'b0; phase = 0;
        end
      endcase
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [36:0] e;
    logic [31:0] last_data;
    last_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin last_data = '0; continue; end
      if (c_done) begin
        if (exp_q.size() == 0) fail_now("unexpected_c_done");
        else begin
          e = exp_q.pop_front();
          check("c_response", {28'd0, c_response}, {28'd0, e[35:32]});
          if (e[36]) begin
            check("c_load_data", c_load_data, e[31:0]);
            last_data = e[31:0];
          end
        end
      end else begin
        check("c_load_data_hold", c_load_data, last_data);
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat, k;
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic [31:0] bases [4];
    bases[0] = 32'h1000; bases[1] = 32'h1010; bases[2] = 32'h2000; bases[3] = 32'h3040;

    rst_n = 1'b0; c_cmd = CMD_NONE; c_address = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_c_done", {31'd0, c_done}, 32'd0);
    check("rst_c_response", {28'd0, c_response}, {28'd0, RSP_SUCCESS});
    check("rst_c_load_data", c_load_data, 32'd0);
    check("rst_m_req_valid", {31'd0, m_req_valid}, 32'd0);
    check("rst_m_req_addr", m_req_addr, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Cold miss, then back-to-back hits presented in each done cycle.
    issue(CMD_EXECUTE, 32'h1000, -1, lat);
    issue(CMD_EXECUTE, 32'h1004, -1, lat); check("hit_latency_1004", 32'(lat), 32'd1);
    issue(CMD_EXECUTE, 32'h1008, -1, lat); check("hit_latency_1008", 32'(lat), 32'd1);
    issue(CMD_EXECUTE, 32'h100C, -1, lat); check("hit_latency_100c", 32'(lat), 32'd1);
    idle(2);

    issue(CMD_EXECUTE, 32'h1002, -1, lat); check("missaligned_latency", 32'(lat), 32'd1);
    idle(1);

    issue(CMD_FLUSH_ALL, 32'h0, -1, lat); check("flush_latency", 32'(lat), 32'd1);
    issue(CMD_EXECUTE, 32'h1000, -1, lat);
    idle(2);

    // Erroring beat: whole burst consumed, line stays invalid.
    issue(CMD_EXECUTE, 32'h2000, 2, lat);
    idle(1);
    issue(CMD_EXECUTE, 32'h2004, -1, lat);
    idle(1);

    issue(4'd7, 32'h0, -1, lat); check("unknown_latency", 32'(lat), 32'd1);
    idle(2);

    // Reset asserted mid-fill.
    err_beat = -1;
    req_exp_q.push_back(32'h1000);
    c_cmd = CMD_EXECUTE; c_address = 32'h1000;
    k = 0;
    while (mem_beat < 2 && k < 200) begin @(posedge clk); #1; k++; end
    if (mem_beat < 2) fail_now("fill_wait_timeout");
    rst_n = 1'b0;
    c_cmd = CMD_NONE;
    #1;
    check("async_rst_c_done", {31'd0, c_done}, 32'd0);
    check("async_rst_c_response", {28'd0, c_response}, {28'd0, RSP_SUCCESS});
    check("async_rst_c_load_data", c_load_data, 32'd0);
    check("async_rst_m_req_valid", {31'd0, m_req_valid}, 32'd0);
    check("async_rst_m_req_addr", m_req_addr, 32'd0);
    exp_q.delete();
    req_exp_q.delete();
    model_valid = 1'b0; model_hits = 0; model_misses = 0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    issue(CMD_EXECUTE, 32'h1000, -1, lat);
    idle(2);
`ifdef ARMLEOCPU_IFETCH_RESP_STATS_EN
    check("stat_hits_after_reset", stat_hits, 32'd0);
    check("stat_misses_after_reset", stat_misses, 32'd1);
`endif

    // Randomized traffic.
    stray_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 9);
      if (k == 0) begin cmd = CMD_FLUSH_ALL; addr = $urandom; end
      else if (k == 1) begin cmd = 4'($urandom_range(5, 15)); addr = $urandom; end
      else if (k == 2) begin cmd = CMD_EXECUTE; addr = bases[$urandom_range(0, 3)] | 32'($urandom_range(1, 15)); addr[1:0] = 2'($urandom_range(1, 3)); end
      else begin cmd = CMD_EXECUTE; addr = bases[$urandom_range(0, 3)] + 32'(4 * $urandom_range(0, LW - 1)); end
      issue(cmd, addr, ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, LW - 1)) : -1, lat);
      if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 2));
    end
    stray_en = 1'b0;
    idle(6);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("req_exp_q_drained", 32'(req_exp_q.size()), 32'd0);
`ifdef ARMLEOCPU_IFETCH_RESP_STATS_EN
    check("stat_hits_final", stat_hits, 32'(model_hits));
    check("stat_misses_final", stat_misses, 32'(model_misses));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
